// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    MD_WAIT = 2'd1
  } state_t;

  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use detector: a load in EX whose destination feeds an operand of the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int RW = 5
) (
  input  logic          ExMemRead,
  input  logic [RW-1:0] ExRd,
  input  logic [RW-1:0] IdRs1,
  input  logic [RW-1:0] IdRs2,
  output logic          LoadUse
);

  logic rd_nonzero_s;
  logic rd_match_s;

  assign rd_nonzero_s = (ExRd != RW'(REG_ZERO));
  assign rd_match_s   = (ExRd == IdRs1) || (ExRd == IdRs2);
  assign LoadUse      = ExMemRead && rd_nonzero_s && rd_match_s;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use stalls, branch flushes,
// multi-cycle MUL/DIV occupancy of EX, memory wait states and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RW     = 5,
  parameter int MD_LAT = 4,
  parameter int CW     = 16
) (
  input  logic          Clk,
  input  logic          Rst,
  input  logic [RW-1:0] IdRs1,
  input  logic [RW-1:0] IdRs2,
  input  logic [RW-1:0] ExRd,
  input  logic          ExMemRead,
  input  logic          BranchTaken,
  input  logic          MdStart,
  input  logic          MemStall,
  output logic          PcEn,
  output logic          IfIdEn,
  output logic          IfIdFlush,
  output logic          IdExEn,
  output logic          IdExFlush,
  output logic          ExMemEn,
  output logic          ExMemFlush,
  output logic          MemWbEn,
  output logic          MdBusy,
  output logic [CW-1:0] StallCnt
);

  localparam int MCW = (MD_LAT > 2) ? $clog2(MD_LAT) : 1;
  localparam logic [MCW-1:0] MD_LOAD = MCW'(MD_LAT - 2);

  state_t          state_r;
  state_t          state_nxt_s;
  logic [MCW-1:0]  md_cnt_r;
  logic [MCW-1:0]  md_cnt_nxt_s;
  logic [CW-1:0]   stall_cnt_r;
  logic            stall_s;
  logic            load_use_s;

  hazard_detect #(.RW(RW)) u_hazard_detect (
    .ExMemRead (ExMemRead),
    .ExRd      (ExRd),
    .IdRs1     (IdRs1),
    .IdRs2     (IdRs2),
    .LoadUse   (load_use_s)
  );

  // Next-state and output decode in priority order: Rst, MemStall, MD_WAIT, MdStart, branch, load-use.
  always_comb begin
    state_nxt_s  = state_r;
    md_cnt_nxt_s = md_cnt_r;
    stall_s      = 1'b0;
    PcEn         = 1'b1;
    IfIdEn       = 1'b1;
    IfIdFlush    = 1'b0;
    IdExEn       = 1'b1;
    IdExFlush    = 1'b0;
    ExMemEn      = 1'b1;
    ExMemFlush   = 1'b0;
    MemWbEn      = 1'b1;
    MdBusy       = 1'b0;
    if (Rst) begin
      PcEn         = 1'b0;
      IfIdEn       = 1'b0;
      IdExEn       = 1'b0;
      ExMemEn      = 1'b0;
      MemWbEn      = 1'b0;
      state_nxt_s  = RUN;
      md_cnt_nxt_s = {MCW{1'b0}};
    end else if (MemStall) begin
      PcEn    = 1'b0;
      IfIdEn  = 1'b0;
      IdExEn  = 1'b0;
      ExMemEn = 1'b0;
      MemWbEn = 1'b0;
      MdBusy  = (state_r == MD_WAIT);
      stall_s = 1'b1;
    end else begin
      case (state_r)
        MD_WAIT: begin
          MdBusy = 1'b1;
          if (md_cnt_r != {MCW{1'b0}}) begin
            PcEn         = 1'b0;
            IfIdEn       = 1'b0;
            IdExEn       = 1'b0;
            ExMemFlush   = 1'b1;
            md_cnt_nxt_s = md_cnt_r - MCW'(1);
            stall_s      = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        RUN: begin
          // MdBusy covers the whole EX occupancy, including the issuing cycle.
          if (MdStart) begin
            MdBusy       = 1'b1;
            PcEn         = 1'b0;
            IfIdEn       = 1'b0;
            IdExEn       = 1'b0;
            ExMemFlush   = 1'b1;
            state_nxt_s  = MD_WAIT;
            md_cnt_nxt_s = MD_LOAD;
            stall_s      = 1'b1;
          end else if (BranchTaken) begin
            IfIdFlush = 1'b1;
            IdExFlush = 1'b1;
          end else if (load_use_s) begin
            PcEn      = 1'b0;
            IfIdEn    = 1'b0;
            IdExFlush = 1'b1;
            stall_s   = 1'b1;
          end else begin
            state_nxt_s = RUN;
          end
        end
        default: begin
          state_nxt_s  = RUN;
          md_cnt_nxt_s = {MCW{1'b0}};
        end
      endcase
    end
  end

  // FSM state, MUL/DIV down-counter and saturating stall counter.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r     <= RUN;
      md_cnt_r    <= {MCW{1'b0}};
      stall_cnt_r <= {CW{1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      md_cnt_r <= md_cnt_nxt_s;
      if (stall_s && (stall_cnt_r != {CW{1'b1}})) begin
        stall_cnt_r <= stall_cnt_r + CW'(1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
    end
  end

  assign StallCnt = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl; a narrow-counter instance covers saturation.
module tb_pipe_hazard_ctrl;

  localparam int RW = 5;

  // Output vector order: PcEn IfIdEn IfIdFlush IdExEn IdExFlush ExMemEn ExMemFlush MemWbEn MdBusy
  localparam logic [8:0] O_DEF   = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] O_ZERO  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_LU    = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] O_BR    = 9'b1_1_1_1_1_1_0_1_0;
  localparam logic [8:0] O_MDS   = 9'b0_0_0_0_0_1_1_1_1;
  localparam logic [8:0] O_MDE   = 9'b1_1_0_1_0_1_0_1_1;
  localparam logic [8:0] O_MS_MD = 9'b0_0_0_0_0_0_0_0_1;

  logic          Clk = 1'b0;
  logic          Rst;
  logic [RW-1:0] IdRs1, IdRs2, ExRd;
  logic          ExMemRead, BranchTaken, MdStart, MemStall;
  logic          PcEn, IfIdEn, IfIdFlush, IdExEn, IdExFlush, ExMemEn, ExMemFlush, MemWbEn, MdBusy;
  logic [15:0]   StallCnt;
  logic          s_PcEn, s_IfIdEn, s_IfIdFlush, s_IdExEn, s_IdExFlush;
  logic          s_ExMemEn, s_ExMemFlush, s_MemWbEn, s_MdBusy;
  logic [3:0]    s_StallCnt;
  logic [8:0]    outs;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 Clk = ~Clk;

  assign outs = {PcEn, IfIdEn, IfIdFlush, IdExEn, IdExFlush, ExMemEn, ExMemFlush, MemWbEn, MdBusy};

  pipe_hazard_ctrl #(.RW(RW), .MD_LAT(4), .CW(16)) dut (
    .Clk(Clk), .Rst(Rst), .IdRs1(IdRs1), .IdRs2(IdRs2), .ExRd(ExRd),
    .ExMemRead(ExMemRead), .BranchTaken(BranchTaken), .MdStart(MdStart), .MemStall(MemStall),
    .PcEn(PcEn), .IfIdEn(IfIdEn), .IfIdFlush(IfIdFlush), .IdExEn(IdExEn), .IdExFlush(IdExFlush),
    .ExMemEn(ExMemEn), .ExMemFlush(ExMemFlush), .MemWbEn(MemWbEn), .MdBusy(MdBusy),
    .StallCnt(StallCnt)
  );

  pipe_hazard_ctrl #(.RW(RW), .MD_LAT(4), .CW(4)) dut_sat (
    .Clk(Clk), .Rst(Rst), .IdRs1(IdRs1), .IdRs2(IdRs2), .ExRd(ExRd),
    .ExMemRead(ExMemRead), .BranchTaken(BranchTaken), .MdStart(MdStart), .MemStall(MemStall),
    .PcEn(s_PcEn), .IfIdEn(s_IfIdEn), .IfIdFlush(s_IfIdFlush), .IdExEn(s_IdExEn),
    .IdExFlush(s_IdExFlush), .ExMemEn(s_ExMemEn), .ExMemFlush(s_ExMemFlush), .MemWbEn(s_MemWbEn),
    .MdBusy(s_MdBusy), .StallCnt(s_StallCnt)
  );

  task automatic clear_inputs();
    Rst = 1'b0; IdRs1 = '0; IdRs2 = '0; ExRd = '0;
    ExMemRead = 1'b0; BranchTaken = 1'b0; MdStart = 1'b0; MemStall = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge Clk); clear_inputs(); Rst = 1'b1; #1;
    total_cnt++;
    if (outs !== O_ZERO) $display("FAIL reset_outs got=%b exp=%b", outs, O_ZERO); else pass_cnt++;
    @(negedge Clk); Rst = 1'b0; #1;
    total_cnt++;
    if (StallCnt !== 16'd0) $display("FAIL reset_cnt got=%0d exp=0", StallCnt); else pass_cnt++;
    total_cnt++;
    if (outs !== O_DEF) $display("FAIL reset_release got=%b exp=%b", outs, O_DEF); else pass_cnt++;
  endtask

  task automatic test_load_use();
    @(negedge Clk); ExMemRead = 1'b1; ExRd = 5'd5; IdRs1 = 5'd3; IdRs2 = 5'd5; #1;
    total_cnt++;
    if (outs !== O_LU) $display("FAIL lu_rs2 got=%b exp=%b", outs, O_LU); else pass_cnt++;
    @(negedge Clk); clear_inputs(); #1;
    total_cnt++;
    if (outs !== O_DEF) $display("FAIL lu_one_cycle got=%b exp=%b", outs, O_DEF); else pass_cnt++;
    total_cnt++;
    if (StallCnt !== 16'd1) $display("FAIL lu_cnt got=%0d exp=1", StallCnt); else pass_cnt++;
    @(negedge Clk); ExMemRead = 1'b1; ExRd = 5'd9; IdRs1 = 5'd9; IdRs2 = 5'd2; #1;
    total_cnt++;
    if (outs !== O_LU) $display("FAIL lu_rs1 got=%b exp=%b", outs, O_LU); else pass_cnt++;
    @(negedge Clk); ExMemRead = 1'b0; #1;
    total_cnt++;
    if (outs !== O_DEF) $display("FAIL lu_not_load got=%b exp=%b", outs, O_DEF); else pass_cnt++;
    @(negedge Clk); ExMemRead = 1'b1; ExRd = 5'd7; IdRs1 = 5'd6; IdRs2 = 5'd31; #1;
    total_cnt++;
    if (outs !== O_DEF) $display("FAIL lu_no_match got=%b exp=%b", outs, O_DEF); else pass_cnt++;
    @(negedge Clk); clear_inputs(); #1;
    total_cnt++;
    if (StallCnt !== 16'd2) $display("FAIL lu_cnt2 got=%0d exp=2", StallCnt); else pass_cnt++;
  endtask

  task automatic test_zero_reg();
    @(negedge Clk); ExMemRead = 1'b1; ExRd = 5'd0; IdRs1 = 5'd0; IdRs2 = 5'd4; #1;
    total_cnt++;
    if (outs !== O_DEF) $display("FAIL zero_reg got=%b exp=%b", outs, O_DEF); else pass_cnt++;
    @(negedge Clk); clear_inputs(); #1;
    total_cnt++;
    if (StallCnt !== 16'd2) $display("FAIL zero_reg_cnt got=%0d exp=2", StallCnt); else pass_cnt++;
  endtask

  task automatic test_branch();
    @(negedge Clk); BranchTaken = 1'b1; ExMemRead = 1'b1; ExRd = 5'd5; IdRs2 = 5'd5; #1;
    total_cnt++;
    if (outs !== O_BR) $display("FAIL branch_over_lu got=%b exp=%b", outs, O_BR); else pass_cnt++;
    @(negedge Clk); clear_inputs(); #1;
    total_cnt++;
    if (StallCnt !== 16'd2) $display("FAIL branch_cnt got=%0d exp=2", StallCnt); else pass_cnt++;
  endtask

  task automatic test_muldiv();
    int pc_low = 0;
    int busy   = 0;
    logic [8:0] exp;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk); clear_inputs();
      MdStart = (c == 0); BranchTaken = (c == 0); #1;
      exp = (c < 3) ? O_MDS : ((c == 3) ? O_MDE : O_DEF);
      total_cnt++;
      if (outs !== exp) $display("FAIL md_cycle%0d got=%b exp=%b", c, outs, exp); else pass_cnt++;
      if (!PcEn) pc_low++;
      if (MdBusy) busy++;
    end
    total_cnt++;
    if (pc_low != 3) $display("FAIL md_pc_low got=%0d exp=3", pc_low); else pass_cnt++;
    total_cnt++;
    if (busy != 4) $display("FAIL md_busy got=%0d exp=4", busy); else pass_cnt++;
    total_cnt++;
    if (StallCnt !== 16'd5) $display("FAIL md_cnt got=%0d exp=5", StallCnt); else pass_cnt++;
  endtask

  task automatic test_memstall();
    logic [8:0] exp;
    for (int c = 0; c < 7; c++) begin
      @(negedge Clk); clear_inputs();
      MdStart = (c == 0); MemStall = (c == 2) || (c == 3); #1;
      case (c)
        0, 1, 4: exp = O_MDS;
        2, 3:    exp = O_MS_MD;
        5:       exp = O_MDE;
        default: exp = O_DEF;
      endcase
      total_cnt++;
      if (outs !== exp) $display("FAIL ms_cycle%0d got=%b exp=%b", c, outs, exp); else pass_cnt++;
    end
    total_cnt++;
    if (StallCnt !== 16'd10) $display("FAIL ms_cnt got=%0d exp=10", StallCnt); else pass_cnt++;
    @(negedge Clk); MemStall = 1'b1; ExMemRead = 1'b1; ExRd = 5'd5; IdRs1 = 5'd5; #1;
    total_cnt++;
    if (outs !== O_ZERO) $display("FAIL ms_run got=%b exp=%b", outs, O_ZERO); else pass_cnt++;
    @(negedge Clk); clear_inputs(); #1;
    total_cnt++;
    if (StallCnt !== 16'd11) $display("FAIL ms_run_cnt got=%0d exp=11", StallCnt); else pass_cnt++;
  endtask

  task automatic test_rst_mid_md();
    @(negedge Clk); MdStart = 1'b1; #1;
    @(negedge Clk); MdStart = 1'b0; #1;
    total_cnt++;
    if (outs !== O_MDS) $display("FAIL rst_md_wait got=%b exp=%b", outs, O_MDS); else pass_cnt++;
    @(negedge Clk); Rst = 1'b1; #1;
    total_cnt++;
    if (outs !== O_ZERO) $display("FAIL rst_md_outs got=%b exp=%b", outs, O_ZERO); else pass_cnt++;
    @(negedge Clk); Rst = 1'b0; #1;
    total_cnt++;
    if (outs !== O_DEF) $display("FAIL rst_md_abort got=%b exp=%b", outs, O_DEF); else pass_cnt++;
    total_cnt++;
    if (StallCnt !== 16'd0) $display("FAIL rst_md_cnt got=%0d exp=0", StallCnt); else pass_cnt++;
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 15; c++) begin
      @(negedge Clk); MemStall = 1'b1;
    end
    @(negedge Clk); #1;
    total_cnt++;
    if (s_StallCnt !== 4'hF) $display("FAIL sat_reach got=%h exp=f", s_StallCnt); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk); MemStall = 1'b1;
    end
    #1;
    total_cnt++;
    if (s_StallCnt !== 4'hF) $display("FAIL sat_hold got=%h exp=f", s_StallCnt); else pass_cnt++;
    total_cnt++;
    if (StallCnt !== 16'd20) $display("FAIL sat_wide got=%0d exp=20", StallCnt); else pass_cnt++;
    @(negedge Clk); clear_inputs(); Rst = 1'b1;
    @(negedge Clk); Rst = 1'b0; #1;
    total_cnt++;
    if (s_StallCnt !== 4'h0) $display("FAIL sat_rst got=%h exp=0", s_StallCnt); else pass_cnt++;
  endtask

  initial begin
    clear_inputs();
    Rst = 1'b1;
    test_reset();
    test_load_use();
    test_zero_reg();
    test_branch();
    test_muldiv();
    test_memstall();
    test_rst_mid_md();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
